uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 166 ++++++++++++++++
 tb/tb_uart_rx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: oversampled start-bit detection, LSB-first data, stop check.
// Optional parity checking is enabled with the RX_PARITY_EN macro.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int OVS     = 16,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err
`ifdef RX_PARITY_EN
  ,
  output logic            parity_err
`endif
);

  localparam int TMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
  localparam int TW   = $clog2(TMAX);
  localparam int BW   = $clog2(DBIT);

  localparam logic [TW-1:0] T_HALF = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] T_BIT  = TW'(OVS - 1);
  localparam logic [TW-1:0] T_STOP = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DBIT - 1);

`ifdef RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
`endif

  state_t            state_q, state_d;
  logic              rx_meta_q, rx_s_q;
  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DBIT-1:0]   shreg_q, shreg_d;
  logic [DBIT-1:0]   dout_q, dout_d;
  logic              done_q, done_d;
  logic              frame_err_q, frame_err_d;
`ifdef RX_PARITY_EN
  logic              parity_bit_q, parity_bit_d;
  logic              parity_err_q, parity_err_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      dout_q      <= '0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef RX_PARITY_EN
      parity_bit_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      dout_q      <= dout_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
`ifdef RX_PARITY_EN
      parity_bit_q <= parity_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    dout_d      = dout_q;
    done_d      = 1'b0;
    frame_err_d = frame_err_q;
`ifdef RX_PARITY_EN
    parity_bit_d = parity_bit_q;
    parity_err_d = parity_err_q;
`endif
    case (state_q)
      // Start detection is tick-independent so the first low sample is never missed.
      IDLE: if (!rx_s_q) begin
        tick_cnt_d = '0;
        state_d    = START;
      end
      START: if (tick) begin
        if (tick_cnt_q == T_HALF) begin
          if (!rx_s_q) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end
      DATA: if (tick) begin
        if (tick_cnt_q == T_BIT) begin
          tick_cnt_d = '0;
          shreg_d    = {rx_s_q, shreg_q[DBIT-1:1]};
          if (bit_cnt_q == B_LAST) begin
`ifdef RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end
`ifdef RX_PARITY_EN
      PARITY: if (tick) begin
        if (tick_cnt_q == T_BIT) begin
          tick_cnt_d   = '0;
          parity_bit_d = rx_s_q;
          state_d      = STOP;
        end else begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end
`endif
      STOP: if (tick) begin
        if (tick_cnt_q == T_STOP) begin
          done_d      = 1'b1;
          dout_d      = shreg_q;
          frame_err_d = !rx_s_q;
`ifdef RX_PARITY_EN
          parity_err_d = (^shreg_q) ^ parity_bit_q;
`endif
          // A low stop bit parks in BRK so a held-low line cannot retrigger.
          state_d = rx_s_q ? IDLE : BRK;
        end else begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end
      BRK: if (tick && rx_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = frame_err_q;
`ifdef RX_PARITY_EN
  assign parity_err   = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at OVS=16 with a tick on every clock.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
`ifdef RX_PARITY_EN
  logic       parity_err;
`endif

  int checks = 0;
  int errors = 0;

  uart_rx #(.DBIT(8), .OVS(16), .SB_TICK(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .rx           (rx),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err)
`ifdef RX_PARITY_EN
    ,
    .parity_err   (parity_err)
`endif
  );

  always #5 clk = ~clk;

  // Pulse recorder: captures outputs on every rx_done_tick and flags wide pulses.
  int         done_cnt = 0;
  int         long_pulse = 0;
  logic       prev_done = 1'b0;
  logic [7:0] cap_dout [64];
  logic       cap_fe   [64];
  logic       cap_pe   [64];

  always @(negedge clk) begin
    if (rx_done_tick === 1'b1) begin
      if (done_cnt < 64) begin
        cap_dout[done_cnt] = dout;
        cap_fe[done_cnt]   = frame_err;
`ifdef RX_PARITY_EN
        cap_pe[done_cnt]   = parity_err;
`else
        cap_pe[done_cnt]   = 1'b0;
`endif
      end
      if (prev_done) long_pulse++;
      done_cnt++;
    end
    prev_done = (rx_done_tick === 1'b1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v,
                            input logic use_par, input logic par);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (use_par) drive_bit(par);
    drive_bit(stop_v);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(4);
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", dout); end
    checks++; if (rx_done_tick !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", rx_done_tick); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_fe got %b exp 0", frame_err); end
`ifdef RX_PARITY_EN
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_pe got %b exp 0", parity_err); end
`endif
    rst_n = 1'b1;
    idle(10);
  endtask

  task automatic test_basic();
    int base;
    base = done_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    idle(20);
    checks++; if (done_cnt - base !== 1) begin errors++; $display("FAIL basic_count got %0d exp 1", done_cnt - base); end
    checks++; if (cap_dout[base] !== 8'hA5) begin errors++; $display("FAIL basic_dout got %h exp a5", cap_dout[base]); end
    checks++; if (cap_fe[base] !== 1'b0) begin errors++; $display("FAIL basic_fe got %b exp 0", cap_fe[base]); end
    checks++; if (long_pulse !== 0) begin errors++; $display("FAIL basic_pulse_width got %0d wide pulses exp 0", long_pulse); end
    checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL basic_hold got %h exp a5", dout); end
    base = done_cnt;
    send_frame(8'h12, 1'b1, 1'b0, 1'b0);
    idle(20);
    checks++; if (cap_dout[base] !== 8'h12) begin errors++; $display("FAIL basic_order got %h exp 12", cap_dout[base]); end
    // restore A5 as the value the glitch test expects to be held
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    idle(20);
  endtask

  task automatic test_glitch();
    int base;
    base = done_cnt;
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(60);
    checks++; if (done_cnt - base !== 0) begin errors++; $display("FAIL glitch_count got %0d exp 0", done_cnt - base); end
    checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL glitch_dout got %h exp a5", dout); end
  endtask

  task automatic test_break();
    int base;
    base = done_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(8'h3C >> i);
    rx = 1'b0;
    idle(40);
    checks++; if (done_cnt - base !== 1) begin errors++; $display("FAIL break_count_low got %0d exp 1", done_cnt - base); end
    rx = 1'b1;
    idle(60);
    checks++; if (done_cnt - base !== 1) begin errors++; $display("FAIL break_retrigger got %0d exp 1", done_cnt - base); end
    checks++; if (cap_dout[base] !== 8'h3C) begin errors++; $display("FAIL break_dout got %h exp 3c", cap_dout[base]); end
    checks++; if (cap_fe[base] !== 1'b1) begin errors++; $display("FAIL break_fe got %b exp 1", cap_fe[base]); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL break_fe_hold got %b exp 1", frame_err); end
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    idle(20);
    checks++; if (done_cnt - base !== 2) begin errors++; $display("FAIL break_next_count got %0d exp 2", done_cnt - base); end
    checks++; if (cap_dout[base+1] !== 8'h11) begin errors++; $display("FAIL break_next_dout got %h exp 11", cap_dout[base+1]); end
    checks++; if (cap_fe[base+1] !== 1'b0) begin errors++; $display("FAIL break_next_fe got %b exp 0", cap_fe[base+1]); end
  endtask

  task automatic test_back_to_back();
    int base;
    base = done_cnt;
    send_frame(8'h00, 1'b1, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    idle(20);
    checks++; if (done_cnt - base !== 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", done_cnt - base); end
    checks++; if (cap_dout[base] !== 8'h00) begin errors++; $display("FAIL b2b_dout0 got %h exp 00", cap_dout[base]); end
    checks++; if (cap_fe[base] !== 1'b0) begin errors++; $display("FAIL b2b_fe0 got %b exp 0", cap_fe[base]); end
    checks++; if (cap_dout[base+1] !== 8'hFF) begin errors++; $display("FAIL b2b_dout1 got %h exp ff", cap_dout[base+1]); end
    checks++; if (cap_fe[base+1] !== 1'b0) begin errors++; $display("FAIL b2b_fe1 got %b exp 0", cap_fe[base+1]); end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    base = done_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(8'h5A >> i);
    rx = 1'b1;            // data bit 4 of 0x5A
    idle(8);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL rstmid_dout got %h exp 00", dout); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_fe got %b exp 0", frame_err); end
    rst_n = 1'b1;
    idle(60);             // frame abandoned, line idles high
    checks++; if (done_cnt - base !== 0) begin errors++; $display("FAIL rstmid_count got %0d exp 0", done_cnt - base); end
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    idle(20);
    checks++; if (done_cnt - base !== 1) begin errors++; $display("FAIL rstmid_next_count got %0d exp 1", done_cnt - base); end
    checks++; if (cap_dout[base] !== 8'h5A) begin errors++; $display("FAIL rstmid_next_dout got %h exp 5a", cap_dout[base]); end
  endtask

`ifdef RX_PARITY_EN
  task automatic test_parity();
    int base;
    base = done_cnt;
    send_frame(8'h01, 1'b1, 1'b1, 1'b0);
    idle(20);
    send_frame(8'h01, 1'b1, 1'b1, 1'b1);
    idle(20);
    checks++; if (done_cnt - base !== 2) begin errors++; $display("FAIL parity_count got %0d exp 2", done_cnt - base); end
    checks++; if (cap_pe[base] !== 1'b1) begin errors++; $display("FAIL parity_bad got %b exp 1", cap_pe[base]); end
    checks++; if (cap_pe[base+1] !== 1'b0) begin errors++; $display("FAIL parity_good got %b exp 0", cap_pe[base+1]); end
    checks++; if (cap_dout[base+1] !== 8'h01) begin errors++; $display("FAIL parity_dout got %h exp 01", cap_dout[base+1]); end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_break();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef RX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
